// File: rtl/enemy_march_ctrl.sv
// Marching enemy sprite controller: steps sideways every FRAMES_PER_STEP frames,
// drops a row at each edge, dies on hit, respawns after RESPAWN_FRAMES, latches on landing.
module enemy_march_ctrl #(
  parameter int START_X         = 100,
  parameter int START_Y         = 60,
  parameter int STEP_X          = 8,
  parameter int STEP_Y          = 16,
  parameter int LEFT_BOUND      = 8,
  parameter int RIGHT_BOUND     = 616,
  parameter int FLOOR_Y         = 400,
  parameter int FRAMES_PER_STEP = 4,
  parameter int RESPAWN_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        hit,
  output logic [10:0] posX,
  output logic [10:0] posY,
  output logic        alive,
  output logic        dir,
  output logic        landed,
  output logic        step_pulse
);

  localparam int DIV_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);

  typedef enum logic [1:0] {
    MARCH  = 2'd0,
    DROP   = 2'd1,
    DEAD   = 2'd2,
    LANDED = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic [10:0]        r_pos_x, w_pos_x_n;
  logic [10:0]        r_pos_y, w_pos_y_n;
  logic               r_dir, w_dir_n;
  logic               r_alive, w_alive_n;
  logic               r_landed, w_landed_n;
  logic               r_step_pulse, w_step_pulse_n;
  logic [DIV_W-1:0]   r_div, w_div_n;
  logic [RSP_W-1:0]   r_resp, w_resp_n;

  logic               w_qtick;
  logic               w_div_last;
  logic [11:0]        w_right_sum;
  logic [11:0]        w_drop_sum;
  logic               w_at_right;
  logic               w_at_left;
  logic               w_at_floor;

  assign w_qtick    = frame_tick & enable;
  assign w_div_last = (r_div == DIV_W'(FRAMES_PER_STEP - 1));

  // Bounds math is one bit wider than the position so the compare cannot wrap.
  assign w_right_sum = {1'b0, r_pos_x} + 12'(STEP_X);
  assign w_drop_sum  = {1'b0, r_pos_y} + 12'(STEP_Y);
  assign w_at_right  = (w_right_sum > 12'(RIGHT_BOUND));
  assign w_at_left   = ({1'b0, r_pos_x} < 12'(LEFT_BOUND + STEP_X));
  assign w_at_floor  = (w_drop_sum >= 12'(FLOOR_Y));

  // NOTE: every next-state signal is defaulted to its register first, so no
  // path through the case below can leave one unassigned and infer a latch.
  always_comb begin
    w_state_n      = r_state;
    w_pos_x_n      = r_pos_x;
    w_pos_y_n      = r_pos_y;
    w_dir_n        = r_dir;
    w_alive_n      = r_alive;
    w_landed_n     = r_landed;
    w_step_pulse_n = 1'b0;
    w_div_n        = r_div;
    w_resp_n       = r_resp;

    case (r_state)
      MARCH, DROP: begin
        if (hit) begin
          w_state_n = DEAD;
          w_alive_n = 1'b0;
          w_div_n   = '0;
          w_resp_n  = RSP_W'(RESPAWN_FRAMES);
        end else if (w_qtick) begin
          if (!w_div_last) begin
            w_div_n = r_div + DIV_W'(1);
          end else begin
            w_div_n = '0;
            if (r_state == MARCH) begin
              if (r_dir ? w_at_right : w_at_left) begin
                w_state_n = DROP;
              end else begin
                w_pos_x_n      = r_dir ? w_right_sum[10:0] : (r_pos_x - 11'(STEP_X));
                w_step_pulse_n = 1'b1;
              end
            end else begin
              w_pos_y_n      = w_drop_sum[10:0];
              w_dir_n        = ~r_dir;
              w_step_pulse_n = 1'b1;
              if (w_at_floor) begin
                w_state_n  = LANDED;
                w_landed_n = 1'b1;
              end else begin
                w_state_n = MARCH;
              end
            end
          end
        end
      end

      DEAD: begin
        if (w_qtick) begin
          if (r_resp <= RSP_W'(1)) begin
            w_resp_n  = '0;
            w_state_n = MARCH;
            w_pos_x_n = 11'(START_X);
            w_pos_y_n = 11'(START_Y);
            w_dir_n   = 1'b1;
            w_alive_n = 1'b1;
            w_div_n   = '0;
          end else begin
            w_resp_n = r_resp - RSP_W'(1);
          end
        end
      end

      LANDED: begin
      end

      default: w_state_n = MARCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= MARCH;
      r_pos_x      <= 11'(START_X);
      r_pos_y      <= 11'(START_Y);
      r_dir        <= 1'b1;
      r_alive      <= 1'b1;
      r_landed     <= 1'b0;
      r_step_pulse <= 1'b0;
      r_div        <= '0;
      r_resp       <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pos_x      <= w_pos_x_n;
      r_pos_y      <= w_pos_y_n;
      r_dir        <= w_dir_n;
      r_alive      <= w_alive_n;
      r_landed     <= w_landed_n;
      r_step_pulse <= w_step_pulse_n;
      r_div        <= w_div_n;
      r_resp       <= w_resp_n;
    end
  end

  assign posX       = r_pos_x;
  assign posY       = r_pos_y;
  assign alive      = r_alive;
  assign dir        = r_dir;
  assign landed     = r_landed;
  assign step_pulse = r_step_pulse;

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Directed bench for enemy_march_ctrl with default parameters; inputs change
// on the falling edge and outputs are sampled on the following falling edge.
module tb_enemy_march_ctrl;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        enable;
  logic        hit;
  logic [10:0] posX;
  logic [10:0] posY;
  logic        alive;
  logic        dir;
  logic        landed;
  logic        step_pulse;

  int checks   = 0;
  int failures = 0;

  enemy_march_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .hit        (hit),
    .posX       (posX),
    .posY       (posY),
    .alive      (alive),
    .dir        (dir),
    .landed     (landed),
    .step_pulse (step_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All tasks are entered and left on a falling edge.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic hit_pulse();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  initial begin
    int n;
    logic [10:0] y_before;

    reset      = 1'b1;
    frame_tick = 1'b0;
    enable     = 1'b1;
    hit        = 1'b0;
    idle(2);
    reset = 1'b0;

    check("rst_posX", posX, 100);
    check("rst_posY", posY, 60);
    check("rst_alive", alive, 1);
    check("rst_dir", dir, 1);
    check("rst_landed", landed, 0);
    check("rst_step", step_pulse, 0);

    // First step after four ticks
    ticks(3);
    check("t3_posX", posX, 100);
    check("t3_step", step_pulse, 0);
    ticks(1);
    check("t4_posX", posX, 108);
    check("t4_posY", posY, 60);
    check("t4_step", step_pulse, 1);
    idle(1);
    check("t4_step_one_cycle", step_pulse, 0);

    // March to the right edge, turn, drop, march left
    ticks(63 * 4);
    check("s64_posX", posX, 612);
    ticks(4);
    check("s65_posX", posX, 612);
    check("s65_posY", posY, 60);
    check("s65_step", step_pulse, 0);
    check("s65_dir", dir, 1);
    ticks(4);
    check("s66_posY", posY, 76);
    check("s66_dir", dir, 0);
    check("s66_step", step_pulse, 1);
    check("s66_posX", posX, 612);
    ticks(4);
    check("s67_posX", posX, 604);

    // Run to the floor: 1683 steps = 6732 ticks from reset
    do_reset();
    n = 0;
    y_before = posY;
    while (!landed && n < 10000) begin
      y_before = posY;
      ticks(1);
      n++;
    end
    check("land_ticks", n, 6732);
    check("land_prev_posY", y_before, 396);
    check("land_posY", posY, 412);
    check("land_posX", posX, 12);
    check("land_flag", landed, 1);
    check("land_alive", alive, 1);
    check("land_step", step_pulse, 1);
    ticks(12);
    hit_pulse();
    ticks(4);
    check("landed_frozen_posX", posX, 12);
    check("landed_frozen_posY", posY, 412);
    check("landed_frozen_alive", alive, 1);
    check("landed_frozen_flag", landed, 1);
    check("landed_frozen_step", step_pulse, 0);
    do_reset();
    check("landed_reset_flag", landed, 0);
    check("landed_reset_posY", posY, 60);

    // Hit at posX=140, respawn after 60 ticks; hits while dead ignored
    ticks(20);
    check("pre_hit_posX", posX, 140);
    hit_pulse();
    check("hit_alive", alive, 0);
    check("hit_posX", posX, 140);
    ticks(30);
    hit_pulse();
    ticks(29);
    check("dead59_alive", alive, 0);
    check("dead59_posX", posX, 140);
    ticks(1);
    check("respawn_alive", alive, 1);
    check("respawn_posX", posX, 100);
    check("respawn_posY", posY, 60);
    check("respawn_dir", dir, 1);
    check("respawn_step", step_pulse, 0);
    ticks(4);
    check("respawn_div_clear", posX, 108);

    // Hit coincident with the step tick, then frozen timing while dead
    do_reset();
    ticks(3);
    frame_tick = 1'b1;
    hit        = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hit        = 1'b0;
    check("coinc_posX", posX, 100);
    check("coinc_step", step_pulse, 0);
    check("coinc_alive", alive, 0);
    enable = 1'b0;
    ticks(10);
    check("dis_dead_alive", alive, 0);
    check("dis_dead_posX", posX, 100);
    enable = 1'b1;
    ticks(59);
    check("dis_dead59_alive", alive, 0);
    ticks(1);
    check("dis_dead60_alive", alive, 1);

    // Disabled ticks in MARCH do not advance the divider
    do_reset();
    ticks(2);
    enable = 1'b0;
    ticks(10);
    check("dis_march_posX", posX, 100);
    check("dis_march_step", step_pulse, 0);
    enable = 1'b1;
    ticks(2);
    check("dis_march_resume", posX, 108);

    // Reset while dead with 30 ticks remaining
    hit_pulse();
    ticks(30);
    check("dead30_alive", alive, 0);
    do_reset();
    check("rst_dead_alive", alive, 1);
    check("rst_dead_posX", posX, 100);
    check("rst_dead_posY", posY, 60);
    check("rst_dead_landed", landed, 0);
    ticks(4);
    check("rst_dead_march", posX, 108);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_march_ctrl.md
ENEMY_MARCH_CTRL -- requirements
Module: enemy_march_ctrl

Interface
REQ-001 Parameter START_X, default 100, meaning spawn/reset X of sprite top-left, in pixels.
REQ-002 Parameter START_Y, default 60, meaning spawn/reset Y, in pixels.
REQ-003 Parameter STEP_X, default 8, meaning horizontal pixels moved per march step.
REQ-004 Parameter STEP_Y, default 16, meaning vertical pixels moved per drop step.
REQ-005 Parameter LEFT_BOUND, default 8, meaning minimum legal posX.
REQ-006 Parameter RIGHT_BOUND, default 616, meaning maximum legal posX (640 minus 24-px sprite).
REQ-007 Parameter FLOOR_Y, default 400, meaning posY at or beyond which the enemy has landed.
REQ-008 Parameter FRAMES_PER_STEP, default 4, meaning frame ticks per movement step (>=1).
REQ-009 Parameter RESPAWN_FRAMES, default 60, meaning frame ticks spent dead before respawn (>=1).
REQ-010 clk  input  1  system clock; all state changes on rising edge.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 frame_tick  input  1  one-cycle pulse per video frame (start of vertical blank).
REQ-013 enable  input  1  1 = movement and respawn timing run; 0 = timing frozen.
REQ-014 hit  input  1  one-cycle pulse: enemy struck by a shot.
REQ-015 posX  output  11  registered sprite X, feeds the sprite renderer posX.
REQ-016 posY  output  11  registered sprite Y, feeds the sprite renderer posY.
REQ-017 alive  output  1  1 = sprite shall be drawn.
REQ-018 dir  output  1  1 = marching right, 0 = marching left.
REQ-019 landed  output  1  1 = enemy reached FLOOR_Y (game-over flag).
REQ-020 step_pulse  output  1  one-cycle pulse whenever posX or posY changes by a march/drop step.

Function
REQ-021 States SHALL be MARCH, DROP, DEAD, LANDED; all outputs registered, changes visible the cycle after the sampling edge.
REQ-022 A "qualified tick" SHALL be frame_tick=1 with enable=1; frame_tick with enable=0 SHALL be ignored and all counters hold.
REQ-023 Frame divider SHALL count qualified ticks in MARCH/DROP; the FRAMES_PER_STEP-th qualified tick SHALL be a "step" and clear the divider to 0.
REQ-024 MARCH on step, dir=1: if posX+STEP_X > RIGHT_BOUND go to DROP with no move; else posX += STEP_X, step_pulse=1.
REQ-025 MARCH on step, dir=0: if posX < LEFT_BOUND+STEP_X go to DROP with no move; else posX -= STEP_X, step_pulse=1.
REQ-026 DROP on step: posY += STEP_Y, dir toggles, step_pulse=1; next state LANDED if new posY >= FLOOR_Y, else MARCH.
REQ-027 LANDED: landed=1, alive=1, positions frozen, hit and ticks ignored until reset.
REQ-028 hit=1 in MARCH or DROP SHALL go to DEAD: alive=0, divider cleared, respawn counter loaded with RESPAWN_FRAMES; positions hold.
REQ-029 hit and step in the same cycle: hit wins, no move, step_pulse=0.
REQ-030 hit in DEAD or LANDED SHALL be ignored.
REQ-031 DEAD: each qualified tick decrements respawn counter; the tick that reaches 0 SHALL set posX=START_X, posY=START_Y, dir=1, alive=1, divider=0, state MARCH, step_pulse=0.
REQ-032 Position arithmetic SHALL be 11-bit unsigned; bounds checks prevent underflow/overflow, posX always within [LEFT_BOUND, RIGHT_BOUND].
REQ-033 step_pulse SHALL be 0 in every cycle not covered by REQ-024..026.

Reset
REQ-034 reset=1 SHALL, at the next rising edge, set state MARCH, posX=START_X, posY=START_Y, dir=1, alive=1, landed=0, step_pulse=0, divider=0, respawn counter=0, overriding all other inputs, including mid-DROP, DEAD or LANDED.

Verification
REQ-035 Reset, enable=1, 4 frame_ticks -> after 4th tick posX=108, posY=60, step_pulse high exactly one cycle; ticks 1-3 produce no change.
REQ-036 March right 64 steps -> posX=612; 65th step: no move, state DROP; 66th step: posY=76, dir=0, step_pulse=1; 67th step: posX=604.
REQ-037 Run until posY=396 then a drop step -> posY=412, landed=1; further ticks and hit pulses change nothing.
REQ-038 hit at posX=140 -> alive=0 next cycle, posX holds 140; 59 ticks: alive=0; 60th tick: alive=1, posX=100, posY=60, dir=1.
REQ-039 hit coincident with the 4th tick -> no move, step_pulse=0, alive=0; enable=0 with 10 frame_ticks -> no output change.
REQ-040 reset asserted in DEAD with 30 respawn ticks remaining -> next cycle alive=1, posX=100, posY=60, landed=0.
